// File: rtl/yi_writer_pkg.sv
// Shared types and AXI constants for the Y-vector writer.
package yi_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int         MAX_BURST      = 16;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/yi_fifo.sv
// Synchronous staging FIFO with occupancy count; head word is read combinationally.
module yi_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 64,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/yi_writer.sv
// Streams Y result words into memory over AXI4 write bursts.
// Define YI_WRITER_BURST_EN for bursts of up to 16 beats; otherwise every burst is a single beat.
module yi_writer
    import yi_writer_pkg::*;
#(
    parameter logic [31:0] YVAL_BASE_ADDR = 32'h4000_0000,
    parameter int          FIFO_DEPTH     = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        Write_Begin,
    input  logic [31:0] Write_Length,
    output logic        Write_Done,
    output logic        Write_Err,
    input  logic        input_valid,
    output logic        input_ready,
    input  logic [63:0] input_data,
    output logic [47:0] m_axi_Yi_awaddr,
    output logic [7:0]  m_axi_Yi_awlen,
    output logic        m_axi_Yi_awvalid,
    input  logic        m_axi_Yi_awready,
    output logic        m_axi_Yi_awid,
    output logic [2:0]  m_axi_Yi_awsize,
    output logic [1:0]  m_axi_Yi_awburst,
    output logic        m_axi_Yi_awlock,
    output logic [3:0]  m_axi_Yi_awcache,
    output logic [2:0]  m_axi_Yi_awprot,
    output logic [3:0]  m_axi_Yi_awqos,
    output logic [63:0] m_axi_Yi_wdata,
    output logic [7:0]  m_axi_Yi_wstrb,
    output logic        m_axi_Yi_wlast,
    output logic        m_axi_Yi_wvalid,
    input  logic        m_axi_Yi_wready,
    input  logic        m_axi_Yi_bid,
    input  logic [1:0]  m_axi_Yi_bresp,
    input  logic        m_axi_Yi_bvalid,
    output logic        m_axi_Yi_bready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    logic [31:0]   remaining_q, remaining_d, offset_q, offset_d;
    logic [31:0]   accepted_q, accepted_d, job_len_q, job_len_d;
    logic [3:0]    beat_q, beat_d;
    logic          awvalid_q, awvalid_d, done_q, done_d, err_q, err_d;
    logic [4:0]    burst_len;
    logic [CW-1:0] fifo_count;
    logic [63:0]   fifo_dout;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop, wlast_i;
    logic          unused_bid;

`ifdef YI_WRITER_BURST_EN
    assign burst_len = (remaining_q >= 32'(MAX_BURST)) ? 5'(MAX_BURST) : remaining_q[4:0];
`else
    assign burst_len = 5'd1;
`endif

    assign unused_bid  = m_axi_Yi_bid;
    assign input_ready = (state_q != IDLE) && !fifo_full && (accepted_q < job_len_q);
    assign fifo_push   = input_valid && input_ready;
    assign fifo_pop    = m_axi_Yi_wvalid && m_axi_Yi_wready;
    assign wlast_i     = ({1'b0, beat_q} == burst_len - 5'd1);

    // Address/data outputs are gated so they read zero whenever not offered.
    assign m_axi_Yi_awvalid = awvalid_q;
    assign m_axi_Yi_awaddr  = awvalid_q ? (48'(YVAL_BASE_ADDR) + {13'b0, offset_q, 3'b000}) : '0;
    assign m_axi_Yi_awlen   = awvalid_q ? {3'b000, burst_len - 5'd1} : '0;
    assign m_axi_Yi_wvalid  = (state_q == DATA) && !fifo_empty;
    assign m_axi_Yi_wdata   = m_axi_Yi_wvalid ? fifo_dout : '0;
    assign m_axi_Yi_wlast   = m_axi_Yi_wvalid && wlast_i;
    assign m_axi_Yi_wstrb   = 8'hFF;
    assign m_axi_Yi_bready  = (state_q == RESP);
    assign m_axi_Yi_awid    = 1'b0;
    assign m_axi_Yi_awsize  = AXI_SIZE_8B;
    assign m_axi_Yi_awburst = AXI_BURST_INCR;
    assign m_axi_Yi_awlock  = 1'b0;
    assign m_axi_Yi_awcache = 4'b0011;
    assign m_axi_Yi_awprot  = 3'b000;
    assign m_axi_Yi_awqos   = 4'b0000;
    assign Write_Done       = done_q;
    assign Write_Err        = err_q;

    yi_fifo #(.DEPTH(FIFO_DEPTH), .W(64), .CW(CW)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .din   (input_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        accepted_d  = accepted_q + 32'(fifo_push);
        job_len_d   = job_len_q;
        beat_d      = beat_q;
        awvalid_d   = awvalid_q;
        done_d      = 1'b0;
        err_d       = err_q;
        unique case (state_q)
            IDLE: if (Write_Begin) begin
                err_d = 1'b0;
                if (Write_Length != '0) begin
                    state_d     = ADDR;
                    remaining_d = Write_Length;
                    job_len_d   = Write_Length;
                    offset_d    = '0;
                    accepted_d  = '0;
                end else begin
                    done_d = 1'b1;
                end
            end
            // Only offer the address once the whole burst is staged, so W never starves.
            ADDR: if (awvalid_q && m_axi_Yi_awready) begin
                awvalid_d = 1'b0;
                beat_d    = '0;
                state_d   = DATA;
            end else if (32'(fifo_count) >= 32'(burst_len)) begin
                awvalid_d = 1'b1;
            end
            DATA: if (fifo_pop) begin
                if (wlast_i) begin
                    beat_d  = '0;
                    state_d = RESP;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            RESP: if (m_axi_Yi_bvalid) begin
                remaining_d = remaining_q - 32'(burst_len);
                offset_d    = offset_q + 32'(burst_len);
                if (m_axi_Yi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
                if (remaining_q == 32'(burst_len)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            offset_q    <= '0;
            accepted_q  <= '0;
            job_len_q   <= '0;
            beat_q      <= '0;
            awvalid_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            accepted_q  <= accepted_d;
            job_len_q   <= job_len_d;
            beat_q      <= beat_d;
            awvalid_q   <= awvalid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
